// File: rtl/ifetch_prefetch.sv
// Instruction fetch stage: a synchronous program ROM feeds a DEPTH-entry prefetch FIFO that presents {instruction, PC} to decode.
// Optional IFETCH_PERF_EN adds the issued-request and redirect-cycle counters.
module ifetch_prefetch #(
    parameter int          ADDR_W   = 14,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              rom_req_o,
    output logic [ADDR_W-1:0] rom_adr_o,
    input  logic [31:0]       rom_data_i,
    output logic              inst_valid,
    output logic [31:0]       inst_o,
    output logic [31:0]       inst_pc_o,
    output logic [31:0]       inst_pc_plus_4_o,
    input  logic              inst_ready
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc_reg;
    logic             inflight_reg;
    logic [31:0]      inflight_pc_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [31:0]      mem_inst_reg [DEPTH];
    logic [31:0]      mem_pc_reg   [DEPTH];

    logic [CNT_W:0]   occupancy;
    logic             issue;
    logic             do_write;
    logic             do_pop;

    // Credit covers both stored entries and the one response still on its way from the ROM.
    assign occupancy = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
    assign issue     = !reset && !redirect_valid && (occupancy < DEPTH_C);
    assign do_write  = inflight_reg && !redirect_valid;
    assign do_pop    = inst_valid && inst_ready && !redirect_valid;

    assign rom_req_o        = issue;
    assign rom_adr_o        = fetch_pc_reg[ADDR_W+1:2];
    assign inst_valid       = (count_reg != '0);
    assign inst_o           = mem_inst_reg[rd_ptr_reg];
    assign inst_pc_o        = mem_pc_reg[rd_ptr_reg];
    assign inst_pc_plus_4_o = inst_pc_o + 32'd4;

    always_comb begin
        count_next = count_reg;
        case ({do_write, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
        end else if (redirect_valid) begin
            fetch_pc_reg    <= redirect_pc & ~32'h3;
            inflight_reg    <= 1'b0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                inflight_pc_reg <= fetch_pc_reg;
                fetch_pc_reg    <= fetch_pc_reg + 32'd4;
            end
            if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // Storage entries are reset so the head reads as zero straight out of reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    mem_inst_reg[gi] <= '0;
                    mem_pc_reg[gi]   <= '0;
                end else if (do_write && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_inst_reg[gi] <= rom_data_i;
                    mem_pc_reg[gi]   <= inflight_pc_reg;
                end
            end
        end
    endgenerate

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (issue)          perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: reset/stream vector table, directed corner sequences, and a randomized run against a credit/queue model.
module tb_ifetch_prefetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        rom_req;
    logic [13:0] rom_adr;
    logic [31:0] rom_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        inst_ready;

    logic        r4_valid;
    logic [31:0] r4_pc;
    logic        req4;
    logic [3:0]  adr4;
    logic [31:0] data4;
    logic        valid4;
    logic [31:0] inst4;
    logic [31:0] pc4;
    logic [31:0] pc4p4;
    logic        ready4;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch, perf_flush, perf_fetch4, perf_flush4;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    ifetch_prefetch #(.ADDR_W(14), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rom_req_o(rom_req), .rom_adr_o(rom_adr), .rom_data_i(rom_data),
        .inst_valid(inst_valid), .inst_o(inst), .inst_pc_o(inst_pc),
        .inst_pc_plus_4_o(inst_pc4), .inst_ready(inst_ready)
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch), .perf_flush_cnt(perf_flush)
`endif
    );

    ifetch_prefetch #(.ADDR_W(4), .DEPTH(4), .RESET_PC(32'h0)) dut4 (
        .clock(clock), .reset(reset),
        .redirect_valid(r4_valid), .redirect_pc(r4_pc),
        .rom_req_o(req4), .rom_adr_o(adr4), .rom_data_i(data4),
        .inst_valid(valid4), .inst_o(inst4), .inst_pc_o(pc4),
        .inst_pc_plus_4_o(pc4p4), .inst_ready(ready4)
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch4), .perf_flush_cnt(perf_flush4)
`endif
    );

    // Synchronous ROMs: word k holds k; junk when not read so stale writes show up.
    always @(posedge clock) begin
        rom_data <= rom_req ? 32'(rom_adr) : 32'hDEAD_BEEF;
        data4    <= req4 ? 32'(adr4) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req", 32'(rom_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_pc4", inst_pc4, 32'h4);
`ifdef IFETCH_PERF_EN
        chk("rst_perf_fetch", perf_fetch, 32'h0);
        chk("rst_perf_flush", perf_flush, 32'h0);
`endif
    endtask

    typedef struct {
        logic        ready;
        logic        exp_req;
        logic [13:0] exp_adr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        int          t;
        logic [31:0] pc;
    } ent_t;

    vec_t tbl[8];
    ent_t q[$];

    initial begin
        int          nreq;
        bit          seen;
        int          now;
        logic [31:0] mpc;
        logic        rdy, rv, exp_req, exp_valid;
        logic [31:0] rpc;

        tbl[0] = '{1'b1, 1'b1, 14'd0, 1'b0, 32'h00};
        tbl[1] = '{1'b1, 1'b1, 14'd1, 1'b0, 32'h00};
        tbl[2] = '{1'b1, 1'b1, 14'd2, 1'b1, 32'h00};
        tbl[3] = '{1'b1, 1'b1, 14'd3, 1'b1, 32'h04};
        tbl[4] = '{1'b1, 1'b1, 14'd4, 1'b1, 32'h08};
        tbl[5] = '{1'b1, 1'b1, 14'd5, 1'b1, 32'h0C};
        tbl[6] = '{1'b1, 1'b1, 14'd6, 1'b1, 32'h10};
        tbl[7] = '{1'b1, 1'b1, 14'd7, 1'b1, 32'h14};

        reset = 1'b1;
        r4_valid = 1'b0; r4_pc = 32'h0; ready4 = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1 chk_reset_outputs();
        reset = 1'b0;

        // Reset release streaming with decode always ready
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].ready, 1'b0, 32'h0);
            chk($sformatf("tbl%0d_req", i), 32'(rom_req), 32'(tbl[i].exp_req));
            chk($sformatf("tbl%0d_adr", i), 32'(rom_adr), 32'(tbl[i].exp_adr));
            chk($sformatf("tbl%0d_valid", i), 32'(inst_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].exp_pc);
                chk($sformatf("tbl%0d_inst", i), inst, tbl[i].exp_pc >> 2);
                chk($sformatf("tbl%0d_pc4", i), inst_pc4, tbl[i].exp_pc + 32'd4);
            end
            @(negedge clock);
        end

        // Backpressure: restart at 0, hold decode off for 10 cycles
        drive(1'b0, 1'b1, 32'h0);
        @(negedge clock);
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            nreq += int'(rom_req);
            if (inst_valid) chk("bp_head_pc", inst_pc, 32'h0);
            if (i < 9) @(negedge clock);
        end
        chk("bp_req_count", 32'(nreq), 32'd4);
        chk("bp_req_stopped", 32'(rom_req), 32'd0);
        chk("bp_head_valid", 32'(inst_valid), 32'd1);
        @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'h0);
            chk($sformatf("drain%0d_valid", i), 32'(inst_valid), 32'd1);
            chk($sformatf("drain%0d_pc", i), inst_pc, 32'(4 * i));
            chk($sformatf("drain%0d_inst", i), inst, 32'(i));
            @(negedge clock);
        end

        // Redirect while FIFO holds 3 entries with 1 in flight
        drive(1'b0, 1'b1, 32'h0);
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            @(negedge clock);
        end
        drive(1'b0, 1'b1, 32'h0000_0103);
        chk("rd_req_in_R", 32'(rom_req), 32'd0);
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h0);
        chk("rd_valid_R1", 32'(inst_valid), 32'd0);
        chk("rd_req_R1", 32'(rom_req), 32'd1);
        chk("rd_adr_R1", 32'(rom_adr), 32'h40);
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h0);
        chk("rd_valid_R2", 32'(inst_valid), 32'd0);
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h0);
        chk("rd_valid_R3", 32'(inst_valid), 32'd1);
        chk("rd_pc_R3", inst_pc, 32'h100);
        chk("rd_inst_R3", inst, 32'h40);
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h0);
        chk("rd_pc_R4", inst_pc, 32'h104);
        @(negedge clock);

        // Redirect coinciding with a would-be pop
        drive(1'b1, 1'b1, 32'h200);
        chk("rp_valid_before", 32'(inst_valid), 32'd1);
        @(negedge clock);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            drive(1'b1, 1'b0, 32'h0);
            if (inst_valid) begin
                seen = 1'b1;
                chk("rp_first_pc", inst_pc, 32'h200);
                chk("rp_first_inst", inst, 32'h80);
            end
            @(negedge clock);
        end
        if (!seen) chk("rp_timeout", 32'd0, 32'd1);

        // Narrow ROM address wraps, PC does not
        r4_valid = 1'b1; r4_pc = 32'h3C;
        @(negedge clock);
        r4_valid = 1'b0;
        #1;
        chk("w4_req0", 32'(req4), 32'd1);
        chk("w4_adr0", 32'(adr4), 32'd15);
        @(negedge clock); #1;
        chk("w4_req1", 32'(req4), 32'd1);
        chk("w4_adr1", 32'(adr4), 32'd0);
        @(negedge clock); #1;
        chk("w4_valid", 32'(valid4), 32'd1);
        chk("w4_pc0", pc4, 32'h3C);
        chk("w4_inst0", inst4, 32'd15);
        chk("w4_pc4_0", pc4p4, 32'h40);
        @(negedge clock); #1;
        chk("w4_pc1", pc4, 32'h40);
        chk("w4_inst1", inst4, 32'd0);
        chk("w4_pc4_1", pc4p4, 32'h44);

        // Reset mid-stream with a request in flight
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h0);
        chk("mr_req_before", 32'(rom_req), 32'd1);
        reset = 1'b1;
        #1 chk_reset_outputs();
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0);
        chk("mr_adr0", 32'(rom_adr), 32'd0);
        chk("mr_valid0", 32'(inst_valid), 32'd0);
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h0);
        chk("mr_valid1", 32'(inst_valid), 32'd0);
        @(negedge clock);
        drive(1'b1, 1'b0, 32'h0);
        chk("mr_valid2", 32'(inst_valid), 32'd1);
        chk("mr_pc2", inst_pc, 32'h0);
        chk("mr_inst2", inst, 32'h0);

        // Randomized run against a queue-of-outstanding-fetches model
        @(negedge clock);
        reset = 1'b1;
        #1;
        @(negedge clock);
        reset = 1'b0;
        q.delete();
        now = 0;
        mpc = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = $urandom;
            drive(rdy, rv, rpc);
            exp_req   = !rv && (q.size() < 4);
            exp_valid = (q.size() > 0) && (q[0].t <= now - 2);
            chk("rnd_req", 32'(rom_req), 32'(exp_req));
            if (exp_req) chk("rnd_adr", 32'(rom_adr), 32'(mpc[15:2]));
            chk("rnd_valid", 32'(inst_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("rnd_pc", inst_pc, q[0].pc);
                chk("rnd_inst", inst, 32'(q[0].pc[15:2]));
                chk("rnd_pc4", inst_pc4, q[0].pc + 32'd4);
            end
            if (rv) begin
                q.delete();
                mpc = rpc & ~32'h3;
            end else begin
                if (exp_valid && rdy) void'(q.pop_front());
                if (exp_req) begin
                    q.push_back('{now, mpc});
                    mpc = mpc + 32'd4;
                end
            end
            now++;
            @(negedge clock);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
